// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the MemRam port arbiter:
//   state_t   - arbiter FSM encoding (IDLE, ISSUE, WAIT, DONE)
//   PORT_CPU  - id of the processor LD/ST port (port 0)
//   PORT_LDR  - id of the program/data loader port (port 1)
//   DEF_AW    - default address width
//   DEF_DW    - default data width
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

endpackage

// File: rtl/arb_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
// Combinational two-way picker used by mem_port_arbiter.
//   req0   in  port 0 request
//   req1   in  port 1 request
//   ptr    in  round-robin pointer: port that wins when both request
//   winner out id of the chosen port (only meaningful when req0|req1)
// Build option: MEM_ARB_FIXED_PRIO_EN makes port 0 win every contention
// and ignores ptr.
// ---------------------------------------------------------------------------
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic winner
);

    always_comb begin
        winner = PORT_CPU;
        if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            winner = PORT_CPU;
`else
            winner = ptr;
`endif
        end else if (req1) begin
            winner = PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares a single-port synchronous RAM between the processor data path
// (port 0) and the program/data loader (port 1). One transaction is granted
// at a time; the RAM address/write/read timing is sequenced here and the
// read data is returned on rdata.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Resetn     in   asynchronous active-low reset
//   req0/req1  in   request, held high until the matching ack
//   we0/we1    in   1 = write, 0 = read; stable while req high
//   addr0/1    in   [AW] address; stable while req high
//   wdata0/1   in   [DW] write data; stable while req high
//   ack0/ack1  out  one-cycle completion pulse
//   rdata      out  [DW] read data, valid in the ack cycle, held until the
//                   next read completes
//   mem_addr   out  [AW] RAM address
//   mem_wdata  out  [DW] RAM write data
//   mem_we     out  RAM write enable (only ever high in ISSUE)
//   mem_rdata  in   [DW] RAM read data, registered, one cycle after address
//   busy       out  high whenever the FSM is not in IDLE
//   grant      out  id of the port currently or last served
//
// Build option: MEM_ARB_FIXED_PRIO_EN makes port 0 win every contention;
// that build carries no ptr register.
//
// Timing (cycle 0 = cycle in which req is sampled in IDLE):
//   write: ISSUE in cycle 1 (mem_we high), ack in cycle 2
//   read : ISSUE in cycle 1, WAIT in cycle 2, ack in cycle 3
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
)
(
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant
);

    state_t        state;
    logic          cmd_we;
    logic          winner;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam logic ptr = PORT_CPU;
`else
    logic          ptr;
`endif

    arb_rr2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .ptr    (ptr),
        .winner (winner)
    );

    assign win_we    = (winner == PORT_LDR) ? we1    : we0;
    assign win_addr  = (winner == PORT_LDR) ? addr1  : addr0;
    assign win_wdata = (winner == PORT_LDR) ? wdata1 : wdata0;

    // mem_addr/mem_wdata double as the command address/data registers: they
    // are loaded at the grant edge so the RAM sees them during ISSUE and they
    // simply hold afterwards. cmd_we remembers the direction once mem_we has
    // dropped back to 0.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
            ptr       <= PORT_CPU;
`endif
            grant     <= PORT_CPU;
            cmd_we    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
        end else begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant     <= winner;
                        cmd_we    <= win_we;
                        mem_we    <= win_we;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Writes complete as the RAM takes them; reads need one
                    // more cycle for the registered RAM output.
                    if (cmd_we) begin
                        ack0  <= (grant == PORT_CPU);
                        ack1  <= (grant == PORT_LDR);
                        state <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    rdata <= mem_rdata;
                    ack0  <= (grant == PORT_CPU);
                    ack1  <= (grant == PORT_LDR);
                    state <= DONE;
                end
                DONE: begin
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
                    // The port just served loses the next tie.
                    ptr   <= ~grant;
`endif
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a behavioural registered RAM,
// a shadow memory for expected read data and a scoreboard of expected
// transactions (port, direction, address, data) that is popped on each ack.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          req0, we0, ack0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1, we1, ack1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          grant;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .Clock     (clk),
        .Resetn    (rst_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered single-port RAM
    logic [DW-1:0] ram [0:65535];
    always_ff @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic          port;
        logic          is_read;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] shadow [0:65535];
    int            tests = 0;
    int            fails = 0;
    int            ack0_cnt = 0;
    logic          mptr = 1'b0;
    bit            late_arm = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected winner from the currently driven requests
    function automatic logic pick(input logic r0, input logic r1);
`ifdef MEM_ARB_FIXED_PRIO_EN
        return (r0 && r1) ? 1'b0 : r1;
`else
        return (r0 && r1) ? mptr : r1;
`endif
    endfunction

    task automatic push_txn(input logic port);
        exp_t e;
        e.port    = port;
        e.is_read = port ? !we1 : !we0;
        e.addr    = port ? addr1 : addr0;
        e.wdata   = port ? wdata1 : wdata0;
        if (!e.is_read) shadow[e.addr] = e.wdata;
        e.data    = shadow[e.addr];
        sb.push_back(e);
    endtask

    // Called in cycle 0 of a transaction; returns in the cycle after the ack.
    task automatic await_ack(input string tag, input int exp_lat, input bit drop);
        exp_t e;
        int   n;
        bit   seen;
        n    = 0;
        seen = 1'b0;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
        end else begin
            e = '{port: 1'b0, is_read: 1'b0, addr: '0, wdata: '0, data: '0};
        end
        while (!seen && n < 8) begin
            tick();
            n++;
            check({tag, "_mem_we"}, 32'(mem_we), 32'((n == 1) && !e.is_read));
            if (n == 1) begin
                check({tag, "_grant"}, 32'(grant), 32'(e.port));
                check({tag, "_mem_addr"}, 32'(mem_addr), 32'(e.addr));
                if (!e.is_read) check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(e.wdata));
                if (late_arm) begin
                    req1     = 1'b1;
                    late_arm = 1'b0;
                end
            end
            if (ack0 || ack1) seen = 1'b1;
        end
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_ack0"}, 32'(ack0), 32'(e.port == 1'b0));
        check({tag, "_ack1"}, 32'(ack1), 32'(e.port == 1'b1));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (e.is_read) check({tag, "_rdata"}, 32'(rdata), 32'(e.data));
        if (ack0) ack0_cnt++;
        mptr = ~e.port;
        if (drop) begin
            if (e.port) req1 = 1'b0;
            else        req0 = 1'b0;
        end
        tick();
        check({tag, "_ack_pulse"}, 32'(ack0 | ack1), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int acc;
        int a0_before;

        rst_n  = 1'b0;
        req0   = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1   = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        ram[16'h0010]    = 16'h1234;
        shadow[16'h0010] = 16'h1234;

        // Reset state
        repeat (3) tick();
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        rst_n = 1'b1;
        tick();

        // Port 0 write then read back
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0005; wdata0 = 16'h00AA;
        push_txn(pick(req0, req1));
        await_ack("p0_write", 2, 1'b1);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
        push_txn(pick(req0, req1));
        await_ack("p0_read", 3, 1'b1);

        // Port 1 alone (ptr favours port 1 here, so grant must still be 1)
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
        push_txn(pick(req0, req1));
        await_ack("p1_read", 3, 1'b1);

        // Port 0 alone while ptr favours port 0 again? ptr now favours 0;
        // continuous contention with both requests held across acks
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h1111;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0021; wdata1 = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            push_txn(pick(req0, req1));
            await_ack($sformatf("contend%0d", i), 2, 1'b0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // Read back contention data through port 1
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
        push_txn(pick(req0, req1));
        await_ack("p1_readback", 3, 1'b1);

        // Late arrival: port 1 read raised while port 0 write is in ISSUE
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h3333;
        we1  = 1'b0; addr1 = 16'h0030;
        late_arm = 1'b1;
        push_txn(pick(req0, req1));
        await_ack("late_p0", 2, 1'b1);
        push_txn(pick(req0, req1));
        await_ack("late_p1", 3, 1'b1);

        // req0 held one cycle past ack: a second transaction follows
        a0_before = ack0_cnt;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0040; wdata0 = 16'h4444;
        push_txn(pick(req0, req1));
        await_ack("held1", 2, 1'b0);
        push_txn(pick(req0, req1));
        await_ack("held2", 2, 1'b1);
        check("held_ack0_count", 32'(ack0_cnt - a0_before), 32'd2);

        // Reset during a read's WAIT cycle: dropped, never acked
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
        tick();
        tick();
        check("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack0", 32'(ack0), 32'd0);
        check("mid_rst_ack1", 32'(ack1), 32'd0);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        req0 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            acc = acc | int'(ack0) | int'(ack1) | int'(busy);
        end
        check("mid_rst_no_ack", 32'(acc), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous MemRam between two requesters:
  - port 0: processor data path (LD/ST).
  - port 1: a program/data loader.
- Requesters use a req/ack handshake.
- Grants one requester per transaction using 2-way round-robin, sequences the RAM's address/write/read timing, and returns read data.
- Sits between processador/loader and MemRam, in place of the direct ADDR/DOUT/W connection.

Parameters:
- AW, 16, address width.
- DW, 16, data width.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write (1) / read (0); stable while req0 high.
- addr0  in  AW  port 0 address; stable while req0 high.
- wdata0  in  DW  port 0 write data; stable while req0 high.
- ack0  out  1  one-cycle completion pulse to port 0.
- req1, we1, addr1, wdata1, ack1: same as port 0, for port 1.
- rdata  out  DW  read data; valid in the ack cycle, held until the next read completes.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DW  RAM read data; registered, valid 1 cycle after the address edge.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  id of the port currently or last served.

Behaviour:
- Reset: Resetn low asynchronously forces:
  - state=IDLE, ptr=0, grant=0.
  - ack0=ack1=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0.
  - An in-flight transaction is dropped with no ack; the requester must re-request.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port equal to ptr.
  - On grant: latch winner's we/addr/wdata into command regs, set grant, go to ISSUE.
- ISSUE:
  - mem_addr/mem_wdata driven from command regs.
  - mem_we = latched we, asserted for exactly this one cycle.
  - Next state: write goes to DONE; read goes to WAIT.
- WAIT (reads only): capture mem_rdata into rdata at the end of the cycle; go to DONE.
- DONE:
  - ack[grant]=1 for exactly one cycle.
  - ptr <= ~grant.
  - Next state: IDLE.
- Latency, counted from the cycle req is sampled in IDLE (cycle 0):
  - write: ack in cycle 2.
  - read: ack in cycle 3.
  - Minimum spacing between back-to-back transactions: 3 cycles for writes, 4 cycles for reads.
- Handshake rules:
  - The requester drops req in the cycle after it sees ack.
  - req still high in the IDLE following DONE is a new transaction.
  - The arbiter never acks a port whose req is low at grant time.
  - req deasserted before ack is a protocol violation; the transaction still completes and acks.
- mem_addr/mem_wdata hold their last values outside ISSUE; mem_we is 0 outside ISSUE.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A lone requester is served every transaction regardless of ptr.
- Widths: addresses and data pass unmodified; no arithmetic.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined:
  - Port 0 always wins contention.
  - ptr is not implemented; the grant is still registered.
  - Port 1 can starve.
- Undefined: round-robin as above.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3).
  - port ids (PORT_CPU=1'b0, PORT_LDR=1'b1).
  - default AW/DW.
- Sub-module arb_rr2: combinational 2-way picker; inputs req0, req1, ptr; output winner. The macro selects fixed priority inside it.
- FSM, command regs and rdata register stay in mem_port_arbiter.

Test Plan:
- Reset mid-read: pulse Resetn low during WAIT -> immediately state=IDLE, ack0=ack1=0, mem_we=0, rdata=0; no ack after release.
- Port 0 write, then read: write addr0=16'h0005, wdata0=16'h00AA -> mem_we=1 only in cycle 1, ack0 in cycle 2. Then read addr0=16'h0005 -> ack0 in cycle 3, rdata=16'h00AA.
- Port 1 alone: read addr1=16'h0010 preloaded 16'h1234 -> grant=1, ack1 in cycle 3, rdata=16'h1234; ack0 stays 0.
- Contention: req0 and req1 held continuously with re-request after each ack -> grant sequence 0,1,0,1, ack pulses alternate, each exactly 1 cycle. With MEM_ARB_FIXED_PRIO_EN -> grants 0,0,0,0.
- Simultaneous late arrival: req1 rises while port 0 is in ISSUE -> port 1 served immediately after port 0's DONE; port 0's data unaffected.
- Held req after ack: req0 kept high 1 cycle past ack0 -> second transaction issued; ack0 count = 2.
